// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: FIFO-buffered UART transmitter with per-frame baud select and zero-gap back-to-back frames.
// Build macro UART_PARITY_EN adds an even parity bit (8E1); without it the framing is 8N1.
module uart_fifo_tx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int FIFO_AW = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [2:0]       baud_set,
  input  logic [7:0]       data_byte,
  input  logic             wr_en,
  output logic             full,
  output logic [FIFO_AW:0] fifo_level,
  output logic             Rs232_Tx,
  output logic             Tx_Done,
  output logic             uart_state
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(CLK_HZ / 9600 + 1);

  localparam logic [CW-1:0] DIV_9600   = CW'(CLK_HZ / 9600);
  localparam logic [CW-1:0] DIV_19200  = CW'(CLK_HZ / 19200);
  localparam logic [CW-1:0] DIV_38400  = CW'(CLK_HZ / 38400);
  localparam logic [CW-1:0] DIV_57600  = CW'(CLK_HZ / 57600);
  localparam logic [CW-1:0] DIV_115200 = CW'(CLK_HZ / 115200);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [7:0]         head;
  logic               push;
  logic               pop;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      div;
  logic               bit_end;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
`ifdef UART_PARITY_EN
  logic               parity;
`endif

  function automatic logic [CW-1:0] div_for(input logic [2:0] sel);
    case (sel)
      3'd0:    div_for = DIV_9600;
      3'd1:    div_for = DIV_19200;
      3'd2:    div_for = DIV_38400;
      3'd3:    div_for = DIV_57600;
      default: div_for = DIV_115200;
    endcase
  endfunction

  assign head    = mem[rd_ptr];
  assign push    = wr_en && !full;
  assign bit_end = (cnt == div - 1'b1);
  // A new frame is fetched either from idle or on the very last stop-bit cycle, so frames abut.
  assign pop     = (fifo_level != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= data_byte;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      full       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10: begin
          fifo_level <= fifo_level + 1'b1;
          full       <= (fifo_level == (FIFO_AW + 1)'(DEPTH - 1));
        end
        2'b01: begin
          fifo_level <= fifo_level - 1'b1;
          full       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      div        <= DIV_115200;
      bit_idx    <= '0;
      shift      <= '0;
      Rs232_Tx   <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
`ifdef UART_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      Tx_Done <= 1'b0;
      if (state != IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
      end
      case (state)
        IDLE: Rs232_Tx <= 1'b1;
        START: begin
          if (bit_end) begin
            state    <= DATA;
            Rs232_Tx <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state    <= PARITY;
              Rs232_Tx <= parity;
`else
              state    <= STOP;
              Rs232_Tx <= 1'b1;
`endif
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              shift    <= shift >> 1;
              Rs232_Tx <= shift[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            Rs232_Tx <= 1'b1;
          end
        end
`endif
        STOP: begin
          // Registered pulse, so it is raised one cycle ahead to land on the final stop cycle.
          if (cnt == div - CW'(2)) begin
            Tx_Done <= 1'b1;
          end
          if (bit_end) begin
            state      <= IDLE;
            uart_state <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Loading a frame overrides whatever the state branch chose this cycle.
      if (pop) begin
        state      <= START;
        shift      <= head;
        div        <= div_for(baud_set);
        bit_idx    <= '0;
        cnt        <= '0;
        Rs232_Tx   <= 1'b0;
        uart_state <= 1'b1;
`ifdef UART_PARITY_EN
        parity     <= ^head;
`endif
      end
    end
  end

endmodule
